// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
// Contents: FSM state enum, ALU control codes, default multiplier occupancy.
package hazard_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  localparam int MUL_LAT_DEFAULT = 4;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
// master: pipeline side, drives ID/EX and IF/ID fields plus branch resolution,
//         receives stall/flush/bubble/hold controls.
// slave:  hazard controller side, the mirror image.
interface hazard_ctrl_if;
  logic       idex_mem_read_i;
  logic [4:0] idex_rd_addr_i;
  logic [3:0] idex_alu_ctrl_i;
  logic [4:0] ifid_rs1_addr_i;
  logic [4:0] ifid_rs2_addr_i;
  logic       branch_taken_i;
  logic       pc_write_o;
  logic       ifid_write_o;
  logic       ifid_flush_o;
  logic       idex_bubble_o;
  logic       idex_hold_o;
  logic       mul_done_o;
  logic       busy_o;

  modport master (
    output idex_mem_read_i, idex_rd_addr_i, idex_alu_ctrl_i,
           ifid_rs1_addr_i, ifid_rs2_addr_i, branch_taken_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           idex_hold_o, mul_done_o, busy_o
  );

  modport slave (
    input  idex_mem_read_i, idex_rd_addr_i, idex_alu_ctrl_i,
           ifid_rs1_addr_i, ifid_rs2_addr_i, branch_taken_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           idex_hold_o, mul_done_o, busy_o
  );
endinterface

// File: rtl/hazard_stat_ctr.sv
// rtl/hazard_stat_ctr.sv - 32-bit saturating event counter
// Ports: clk_i (clock), rst_i (sync active-high clear), inc_i (count enable),
//        cnt_o (current count, sticks at all-ones).
module hazard_stat_ctr (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / multiply stall and branch flush controller
// Ports: clk_i (clock), rst_i (sync active-high reset),
//        bus (hazard_ctrl_if.slave: pipeline fields in, stall/flush controls out).
// Optional (HAZARD_CTRL_STATS_EN): stall_cnt_o, flush_cnt_o saturating counters.
// Parameter MUL_LAT: multiplier occupancy of EX in cycles, 2..16.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_ctrl_if.slave        bus
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  // Counter value loaded on detect: the detect cycle itself is the first
  // stall cycle, so MUL_BUSY spends MUL_LAT-2 cycles stalling plus one done cycle.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

  state_t     r_state;
  logic [3:0] r_cnt;

  logic w_idle;
  logic w_busy;
  logic w_rd_match;
  logic w_load_use;
  logic w_mul_det;
  logic w_busy_stall;
  logic w_mul_done;
  logic w_stall;

  assign w_idle = !rst_i && (r_state == ST_IDLE);
  assign w_busy = !rst_i && (r_state == ST_MUL_BUSY);

  assign w_rd_match   = (bus.idex_rd_addr_i == bus.ifid_rs1_addr_i) ||
                        (bus.idex_rd_addr_i == bus.ifid_rs2_addr_i);
  assign w_load_use   = w_idle && bus.idex_mem_read_i &&
                        (bus.idex_rd_addr_i != 5'd0) && w_rd_match;
  assign w_mul_det    = w_idle && (bus.idex_alu_ctrl_i == ALU_MUL);
  assign w_busy_stall = w_busy && (r_cnt != 4'd0);
  assign w_mul_done   = w_busy && (r_cnt == 4'd0);
  assign w_stall      = w_load_use || w_mul_det || w_busy_stall;

  always_comb begin
    bus.pc_write_o    = !w_stall;
    bus.ifid_write_o  = !w_stall;
    // A multiply in ID/EX must be held, never bubbled away, so it wins
    // over a coincident load-use match.
    bus.idex_bubble_o = w_load_use && !w_mul_det;
    bus.idex_hold_o   = w_mul_det || w_busy_stall;
    bus.ifid_flush_o  = w_idle && !w_stall && bus.branch_taken_i;
    bus.mul_done_o    = w_mul_done;
    bus.busy_o        = w_busy;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mul_det) begin
            r_state <= ST_MUL_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        ST_MUL_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic w_stall_ev;
  logic w_flush_ev;

  assign w_stall_ev = !bus.pc_write_o;
  assign w_flush_ev = bus.ifid_flush_o;

  hazard_stat_ctr u_stall_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_ev),
    .cnt_o (stall_cnt_o)
  );

  hazard_stat_ctr u_flush_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_flush_ev),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule
